// File: rtl/cpu_jtag_debug_scan_master.sv
// Scan-side master for the CPU debug module's virtual-JTAG slave.
// Each command performs one IR load (UIR), capture (CDR), a DR_WIDTH-bit
// shift (SDR) and an update (UDR), then returns the captured DR.
// Optional feature macro: SCAN_MASTER_IR_CACHE_EN skips UIR when the
// requested IR matches the one most recently loaded.
module cpu_jtag_debug_scan_master #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = $clog2(DR_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RESP
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] shift_reg;

`ifdef SCAN_MASTER_IR_CACHE_EN
  logic                cache_valid;
  logic [IR_WIDTH-1:0] cache_ir;
  logic [IR_WIDTH-1:0] cache_ir_out;
`endif

  logic phase_end_c;
  logic tck_rise_c;
  logic tck_fall_c;

  // Divider terminal count and tck edge qualifiers for the current phase
  always_comb begin
    phase_end_c = (div_cnt == DIV_W'(TCK_DIV - 1));
    tck_rise_c  = phase_end_c && !vji_tck;
    tck_fall_c  = phase_end_c && vji_tck;
  end

  // Transaction FSM, tck divider, shift register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_ir       <= '0;
      vji_tck      <= 1'b0;
      vji_tdi      <= 1'b0;
      vji_ir_in    <= '0;
      vji_uir      <= 1'b0;
      vji_cdr      <= 1'b0;
      vji_sdr      <= 1'b0;
      vji_udr      <= 1'b0;
      vji_rti      <= 1'b1;
`ifdef SCAN_MASTER_IR_CACHE_EN
      cache_valid  <= 1'b0;
      cache_ir     <= '0;
      cache_ir_out <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            shift_reg <= cmd_dr;
            vji_ir_in <= cmd_ir;
            vji_rti   <= 1'b0;
            cmd_ready <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            vji_tck   <= 1'b0;
`ifdef SCAN_MASTER_IR_CACHE_EN
            if (cache_valid && (cmd_ir == cache_ir)) begin
              state   <= ST_CDR;
              vji_cdr <= 1'b1;
              rsp_ir  <= cache_ir_out;
            end else begin
              state   <= ST_UIR;
              vji_uir <= 1'b1;
            end
`else
            state   <= ST_UIR;
            vji_uir <= 1'b1;
`endif
          end
        end

        ST_UIR, ST_CDR, ST_SDR, ST_UDR: begin
          if (phase_end_c) begin
            div_cnt <= '0;
            vji_tck <= ~vji_tck;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end

          // Sample side: tck rising
          if (tck_rise_c) begin
            if (state == ST_UIR) begin
              rsp_ir <= vji_ir_out;
`ifdef SCAN_MASTER_IR_CACHE_EN
              cache_valid  <= 1'b1;
              cache_ir     <= vji_ir_in;
              cache_ir_out <= vji_ir_out;
`endif
            end
            if (state == ST_SDR) begin
              shift_reg <= {vji_tdo, shift_reg[DR_WIDTH-1:1]};
            end
          end

          // Drive side: tck falling advances the virtual state
          if (tck_fall_c) begin
            case (state)
              ST_UIR: begin
                state   <= ST_CDR;
                vji_uir <= 1'b0;
                vji_cdr <= 1'b1;
              end
              ST_CDR: begin
                state   <= ST_SDR;
                vji_cdr <= 1'b0;
                vji_sdr <= 1'b1;
                vji_tdi <= shift_reg[0];
                bit_cnt <= '0;
              end
              ST_SDR: begin
                if (bit_cnt == CNT_W'(DR_WIDTH - 1)) begin
                  state   <= ST_UDR;
                  vji_sdr <= 1'b0;
                  vji_udr <= 1'b1;
                  vji_tdi <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  vji_tdi <= shift_reg[0];
                end
              end
              ST_UDR: begin
                state     <= ST_RESP;
                vji_udr   <= 1'b0;
                rsp_data  <= shift_reg;
                rsp_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            vji_rti   <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          vji_rti   <= 1'b1;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          vji_tck   <= 1'b0;
          vji_uir   <= 1'b0;
          vji_cdr   <= 1'b0;
          vji_sdr   <= 1'b0;
          vji_udr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_jtag_debug_scan_master.sv
// Bench for cpu_jtag_debug_scan_master: directed commands with a response
// scoreboard, strobe-sequence logging and latency measurement.
`timescale 1ns/1ps
module tb_cpu_jtag_debug_scan_master;

  localparam int unsigned DR_WIDTH = 38;
  localparam int unsigned IR_WIDTH = 2;
  localparam int unsigned TCK_DIV  = 2;
  localparam int LAT_FULL = (DR_WIDTH + 3) * 2 * TCK_DIV;
  localparam int LAT_HIT  = (DR_WIDTH + 2) * 2 * TCK_DIV;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir = '0;
  logic [DR_WIDTH-1:0] cmd_dr = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir;
  logic                vji_tck, vji_tdi, vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic [IR_WIDTH-1:0] vji_ir_out = '0;
  logic                vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic tdo_loop  = 1'b1;
  logic tdo_const = 1'b0;
  assign vji_tdo = tdo_loop ? vji_tdi : tdo_const;

  cpu_jtag_debug_scan_master #(
    .DR_WIDTH(DR_WIDTH), .IR_WIDTH(IR_WIDTH), .TCK_DIV(TCK_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir(rsp_ir),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DR_WIDTH-1:0] data;
    logic [IR_WIDTH-1:0] ir;
    int                  lat;
  } exp_t;

  typedef struct {
    int code;
    int len;
  } run_t;

  exp_t exp_q[$];
  run_t log_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   sdr_rises = 0;
  int   tck_toggles = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe bookkeeping and response scoreboard, sampled on the falling clk edge
  logic seen = 1'b0;
  logic cur_ok = 1'b0;
  exp_t cur;
  logic prev_tck = 1'b0;
  int   run_code = 0;
  int   run_len = 0;
  always @(negedge clk) begin
    int code;
    if (!reset_n) begin
      seen = 1'b0; cur_ok = 1'b0; prev_tck = 1'b0; run_code = 0; run_len = 0;
    end else begin
      check("strobe_onehot", 64'($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) <= 1), 64'd1);
      if (vji_tck != prev_tck) tck_toggles++;
      if (vji_tck && !prev_tck && vji_sdr) sdr_rises++;
      prev_tck = vji_tck;
      code = vji_uir ? 1 : vji_cdr ? 2 : vji_sdr ? 3 : vji_udr ? 4 : 0;
      if (code != run_code) begin
        if (run_code != 0) log_q.push_back('{run_code, run_len});
        run_code = code;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            cur_ok = 1'b0;
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=rsp_valid required=none data=%0h", rsp_data);
          end else begin
            cur = exp_q.pop_front();
            cur_ok = 1'b1;
            check("rsp_latency", 64'(cyc - accept_cyc), 64'(cur.lat));
            check("rsp_ir", 64'(rsp_ir), 64'(cur.ir));
          end
        end
        if (cur_ok) check("rsp_data", 64'(rsp_data), 64'(cur.data));
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [IR_WIDTH-1:0] ir, input logic [DR_WIDTH-1:0] dr,
                       input logic [DR_WIDTH-1:0] exp_data, input logic [IR_WIDTH-1:0] exp_ir,
                       input int lat);
    int n;
    n = 0;
    @(negedge clk);
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=cmd_ready_low required=accept");
      cmd_valid = 1'b0;
    end else begin
      exp_q.push_back('{exp_data, exp_ir, lat});
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      cmd_valid = 1'b0;
      cmd_dr = ~dr;
      cmd_ir = ~ir;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || rsp_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || rsp_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=pending required=done", name);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rti"}, 64'(vji_rti), 64'd1);
    check({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({name, "_others"},
          64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, rsp_valid, rsp_ir}), 64'd0);
    check({name, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0;
    int n;
    int vcnt;
    int exp_codes[4];
    int exp_lens[4];
    logic [IR_WIDTH-1:0] hit_ir;
    int hit_lat;
    int hit_code;

    exp_codes = '{1, 2, 3, 4};
    exp_lens  = '{2 * TCK_DIV, 2 * TCK_DIV, DR_WIDTH * 2 * TCK_DIV, 2 * TCK_DIV};

    // Reset state and idle tck
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    t0 = tck_toggles;
    repeat (200) @(negedge clk);
    check("idle_tck_toggles", 64'(tck_toggles - t0), 64'd0);

    // Loopback
    tdo_loop = 1'b1; vji_ir_out = 2'b01; sdr_rises = 0;
    issue(2'b01, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 2'b01, LAT_FULL);
    wait_done("loopback");
    check("loopback_sdr_rises", 64'(sdr_rises), 64'(DR_WIDTH));

    // Constant tdo and strobe order
    tdo_loop = 1'b0; tdo_const = 1'b1; vji_ir_out = 2'b10;
    log_q.delete();
    issue(2'b10, 38'h01_2345_6789, 38'h3F_FFFF_FFFF, 2'b10, LAT_FULL);
    wait_done("const");
    check("const_log_size", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("const_strobe_code", 64'(log_q[i].code), 64'(exp_codes[i]));
        check("const_strobe_len", 64'(log_q[i].len), 64'(exp_lens[i]));
      end
    end

    // Back-pressure
    tdo_loop = 1'b1; vji_ir_out = 2'b11; rsp_ready = 1'b0;
    issue(2'b00, 38'h15_0F0F_F0F0, 38'h15_0F0F_F0F0, 2'b11, LAT_FULL);
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    check("bp_valid_held", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_release_ready", 64'(cmd_ready), 64'd1);
    check("bp_release_rti", 64'(vji_rti), 64'd1);
    wait_done("bp");

    // Reset in the middle of the DR shift
    vji_ir_out = 2'b01; sdr_rises = 0;
    issue(2'b01, 38'h3C_3333_CCCC, 38'h3C_3333_CCCC, 2'b01, LAT_FULL);
    n = 0;
    while (sdr_rises < 17 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_bit17", 64'(sdr_rises >= 17), 64'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    vcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    check("midrst_no_rsp", 64'(vcnt), 64'd0);
    issue(2'b01, 38'h00_DEAD_BEEF, 38'h00_DEAD_BEEF, 2'b01, LAT_FULL);
    wait_done("after_rst");

    // Repeated IR: cached build skips UIR and reuses the cached readback
`ifdef SCAN_MASTER_IR_CACHE_EN
    hit_ir = 2'b01; hit_lat = LAT_HIT; hit_code = 2;
`else
    hit_ir = 2'b10; hit_lat = LAT_FULL; hit_code = 1;
`endif
    vji_ir_out = 2'b01;
    log_q.delete();
    issue(2'b11, 38'h11_1111_1111, 38'h11_1111_1111, 2'b01, LAT_FULL);
    wait_done("ir11_first");
    check("ir11_first_strobe", 64'(log_q.size() > 0 ? log_q[0].code : 0), 64'd1);
    vji_ir_out = 2'b10;
    log_q.delete();
    issue(2'b11, 38'h22_2222_2222, 38'h22_2222_2222, hit_ir, hit_lat);
    wait_done("ir11_second");
    check("ir11_second_strobe", 64'(log_q.size() > 0 ? log_q[0].code : 0), 64'(hit_code));
    vji_ir_out = 2'b11;
    log_q.delete();
    issue(2'b00, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012, 2'b11, LAT_FULL);
    wait_done("ir00");
    check("ir00_strobe", 64'(log_q.size() > 0 ? log_q[0].code : 0), 64'd1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_jtag_debug_scan_master.md
Name: cpu_jtag_debug_scan_master

Overview:
- Scan-side driver for the CPU debug module's virtual-JTAG slave. It generates tck, tdi, ir_in and the virtual-state strobes (uir/cdr/sdr/udr/rti), and it captures tdo.
- Used by the on-chip debug bridge and the simulation bench to issue debug-register transactions without a physical JTAG host.
- Each command is one transaction: load the 2-bit IR, capture, shift DR_WIDTH bits, then update. The captured DR is returned on the response channel.

Parameters:
- DR_WIDTH, 38, length of the data-register scan; matches the debug module's jdo/sr width.
- IR_WIDTH, 2, width of the virtual IR.
- TCK_DIV, 2, number of clk cycles per tck half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_dr  in  DR_WIDTH  DR value to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_WIDTH  captured tdo bits; bit 0 is the first bit shifted out.
- rsp_ir  out  IR_WIDTH  vji_ir_out value sampled during UIR.
- vji_tck  out  1  generated scan clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  IR presented to the slave.
- vji_ir_out  in  IR_WIDTH  IR readback from the slave.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state indicators.

Behaviour:
- Reset values:
  - Set to 0: vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, rsp_valid, rsp_data, rsp_ir.
  - Set to 1: vji_rti, cmd_ready.
  - Internal: FSM goes to IDLE; IR cache is invalidated.
- tck generation:
  - A divider counts TCK_DIV clk cycles per phase. Each tck period is a low phase followed by a high phase, 2*TCK_DIV clk cycles in total.
  - vji_tck is held low while in IDLE and RESP.
- Data timing:
  - vji_tdi and the state strobes change only on the clk edge that drives tck low (the falling edge).
  - vji_tdo and vji_ir_out are sampled on the clk edge that drives tck high (the rising edge).
- FSM states: IDLE, UIR, CDR, SDR, UDR, RESP.
  - IDLE: vji_rti=1 and cmd_ready=1. When cmd_valid&cmd_ready, latch cmd_ir and cmd_dr, drive vji_ir_in=cmd_ir, clear vji_rti, go to UIR.
  - UIR: one tck period with vji_uir=1. Sample vji_ir_out into rsp_ir on the tck rise. Then go to CDR.
  - CDR: one tck period with vji_cdr=1. Then go to SDR.
  - SDR: exactly DR_WIDTH tck periods with vji_sdr=1.
    - tdi = the shift register's LSB, presented during the low phase.
    - On each tck rise, shift right with tdo entering the MSB.
    - The bit counter runs 0..DR_WIDTH-1; leave SDR when it reaches DR_WIDTH-1 after the rise.
  - UDR: one tck period with vji_udr=1. Then copy the shift register to rsp_data, assert rsp_valid, go to RESP.
  - RESP: hold rsp_valid, rsp_data and rsp_ir until rsp_ready=1. On that handshake clear rsp_valid, set vji_rti=1, return to IDLE.
- Handshake rules:
  - cmd_ready is 0 in every state except IDLE.
  - rsp_valid stays 1 while rsp_ready=0 (back-pressure).
  - A command cannot be accepted on the same cycle as the response handshake; it is taken on the next IDLE cycle at the earliest.
- Latency: rsp_valid rises exactly (DR_WIDTH+3)*2*TCK_DIV clk cycles after the accept edge. With defaults this is 164 cycles.
- Strobe exclusivity: at most one of vji_uir/vji_cdr/vji_sdr/vji_udr/vji_rti is 1 at any time.
- Reset mid-operation: asynchronous return to IDLE with reset values. Any partially shifted data is discarded and no response is issued.
- cmd_dr and cmd_ir may change after the accept cycle without affecting the transaction in flight.

Optional Feature:
- Macro: SCAN_MASTER_IR_CACHE_EN.
- When defined:
  - A valid flag and a last-IR register track the IR most recently loaded through UIR.
  - If an accepted cmd_ir equals the cached IR and the cache is valid, skip UIR and go directly to CDR.
  - On a skip, rsp_ir returns the cached readback value.
  - Latency on a cache hit is (DR_WIDTH+2)*2*TCK_DIV; with defaults, 160 cycles.
  - Reset invalidates the cache.
- When undefined: every command passes through UIR, and latency is always (DR_WIDTH+3)*2*TCK_DIV.

Test Plan:
- Reset check: after reset, expect vji_rti=1, cmd_ready=1 and all other outputs 0. Then 200 idle cycles -> vji_tck never toggles.
- Loopback: tie vji_tdo to vji_tdi. cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A -> rsp_data=38'h2A_5A5A_5A5A; rsp_valid exactly 164 cycles after accept; exactly 38 tck rises while vji_sdr=1.
- Constant tdo: vji_tdo=1, vji_ir_out=2'b10 -> rsp_data=38'h3F_FFFF_FFFF, rsp_ir=2'b10. One uir, one cdr and one udr period are seen, each 4 clk cycles long and in that order.
- Back-pressure: hold rsp_ready=0 for 50 cycles -> rsp_valid stays 1 with data stable and cmd_ready=0. Release -> IDLE on the next cycle.
- Mid-shift reset: assert reset_n=0 at SDR bit 17 -> all outputs go to reset values immediately, and no rsp_valid follows. A new command then completes normally.
- With SCAN_MASTER_IR_CACHE_EN: two commands with cmd_ir=2'b11 -> the second has no vji_uir pulse and 160-cycle latency. A third command with cmd_ir=2'b00 -> UIR present again, 164-cycle latency.
